mem_arbiter: RTL and testbench

- Shares the single-port data/instruction SRAM between two requesters. Port 0 is the MIPS core's memory interface (memread/memwrite/adr/writedata). Port 1 is a host/loader port used to preload programs and inspect results.
- Sits in the top-level device wrapper, between the core and the SRAM.
- Serialises accesses with a registered FSM, translates byte addresses to word addresses and returns read data with a valid strobe.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_sel.sv | 43 ++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encoding, port indices and default sizes.
package mem_arb_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SRAM_AW = 8;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection and last_owner tracking for the two-port SRAM arbiter.
// Tie policy: host priority by default, round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic winner
);

  logic last_owner;
  logic tie_winner;

`ifdef MEM_ARB_RR_EN
  assign tie_winner = ~last_owner;
`else
  assign tie_winner = PORT_HOST;
`endif

  // With no request the index is a don't-care; holding last_owner keeps it stable.
  always_comb begin
    winner = last_owner;
    if (req0 && req1) begin
      winner = tie_winner;
    end else if (req0) begin
      winner = PORT_CORE;
    end else if (req1) begin
      winner = PORT_HOST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= PORT_HOST;
    end else if (upd) begin
      last_owner <= winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core (port 0) and host (port 1) accesses onto the single-port SRAM.
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking instead of host priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SRAM_AW = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [WIDTH-1:0]   p0_adr,
  input  logic [WIDTH-1:0]   p0_wdata,
  output logic               p0_gnt,
  output logic               p0_rvalid,
  output logic [WIDTH-1:0]   p0_rdata,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [WIDTH-1:0]   p1_adr,
  input  logic [WIDTH-1:0]   p1_wdata,
  output logic               p1_gnt,
  output logic               p1_rvalid,
  output logic [WIDTH-1:0]   p1_rdata,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_adr,
  output logic [WIDTH-1:0]   sram_wdata,
  input  logic [WIDTH-1:0]   sram_rdata
);

  arb_state_t         state;
  logic               owner;
  logic               winner;
  logic               upd;
  logic               win_we;
  logic [SRAM_AW-1:0] win_wadr;
  logic [WIDTH-1:0]   win_wdata;

  // Byte-offset bits and bits above the SRAM range are deliberately dropped.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{p0_adr[1:0], p0_adr[WIDTH-1:SRAM_AW+2],
                             p1_adr[1:0], p1_adr[WIDTH-1:SRAM_AW+2]};

  assign upd = (state == IDLE) && (p0_req || p1_req);

  mem_arb_sel u_sel (
    .clk    (clk),
    .reset  (reset),
    .req0   (p0_req),
    .req1   (p1_req),
    .upd    (upd),
    .winner (winner)
  );

  assign win_we    = (winner == PORT_HOST) ? p1_we                  : p0_we;
  assign win_wadr  = (winner == PORT_HOST) ? p1_adr[SRAM_AW+1:2]    : p0_adr[SRAM_AW+1:2];
  assign win_wdata = (winner == PORT_HOST) ? p1_wdata               : p0_wdata;

  assign p0_rdata = (owner == PORT_CORE) ? sram_rdata : '0;
  assign p1_rdata = (owner == PORT_HOST) ? sram_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= PORT_CORE;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      sram_adr   <= '0;
      sram_wdata <= '0;
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          if (p0_req || p1_req) begin
            owner      <= winner;
            sram_cs    <= 1'b1;
            sram_we    <= win_we;
            sram_adr   <= win_wadr;
            sram_wdata <= win_wdata;
            p0_gnt     <= (winner == PORT_CORE);
            p1_gnt     <= (winner == PORT_HOST);
            state      <= ACCESS;
          end
        end
        // SRAM samples the command at this edge; read data follows a cycle later.
        ACCESS: begin
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          state   <= sram_we ? IDLE : RESP;
        end
        RESP: begin
          p0_rvalid <= (owner == PORT_CORE);
          p1_rvalid <= (owner == PORT_HOST);
          state     <= IDLE;
        end
        default: begin
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  a_one_gnt: assert property (@(posedge clk) disable iff (reset) !(p0_gnt && p1_gnt));
  a_one_rvalid: assert property (@(posedge clk) disable iff (reset) !(p0_rvalid && p1_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model and SRAM model.
module tb_mem_arbiter;

  localparam int WIDTH   = 32;
  localparam int SRAM_AW = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               p0_req, p0_we, p1_req, p1_we;
  logic [WIDTH-1:0]   p0_adr, p0_wdata, p1_adr, p1_wdata;
  logic               p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [WIDTH-1:0]   p0_rdata, p1_rdata;
  logic               sram_cs, sram_we;
  logic [SRAM_AW-1:0] sram_adr;
  logic [WIDTH-1:0]   sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Synchronous SRAM: one-edge read latency, output held until the next read.
  logic [WIDTH-1:0] sram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = '0;
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      if (sram_cs) begin
        if (sram_we) sram_mem[sram_adr] <= sram_wdata;
        else         sram_rdata <= sram_mem[sram_adr];
      end
    end
  end

  // Reference model: each grant books the SRAM for a fixed number of cycles
  // (2 for a write, 3 for a read) and schedules its rvalid two cycles out.
  bit               m_gnt0, m_gnt1, m_rv0, m_rv1, m_cs, m_we;
  logic [7:0]       m_adr;
  logic [WIDTH-1:0] m_wdata, m_rdata;
  logic [WIDTH-1:0] mmem [256];
  int               mcyc = 0, free_at = 0, rv_at = -1;
  bit               rv_port, m_last = 1'b1;
  logic [7:0]       rv_adr;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    forever begin
      @(posedge clk or posedge reset);
      m_gnt0 = 0; m_gnt1 = 0; m_rv0 = 0; m_rv1 = 0; m_cs = 0; m_we = 0;
      if (reset) begin
        mcyc = 0; free_at = 0; rv_at = -1; m_last = 1'b1;
      end else begin
        bit w;
        logic [WIDTH-1:0] a;
        mcyc++;
        if (rv_at == mcyc) begin
          if (rv_port) m_rv1 = 1; else m_rv0 = 1;
          m_rdata = mmem[rv_adr];
        end
        if (mcyc >= free_at && (p0_req || p1_req)) begin
          if (p0_req && p1_req) begin
`ifdef MEM_ARB_RR_EN
            w = ~m_last;
`else
            w = 1'b1;
`endif
          end else begin
            w = p1_req;
          end
          m_last = w;
          if (w) m_gnt1 = 1; else m_gnt0 = 1;
          a       = w ? p1_adr : p0_adr;
          m_cs    = 1;
          m_we    = w ? p1_we : p0_we;
          m_adr   = 8'((a / 4) % 256);
          m_wdata = w ? p1_wdata : p0_wdata;
          if (m_we) begin
            mmem[m_adr] = m_wdata;
            free_at = mcyc + 2;
          end else begin
            rv_at = mcyc + 2; rv_port = w; rv_adr = m_adr;
            free_at = mcyc + 3;
          end
        end
      end
    end
  end

  // Per-cycle compare plus observation logs used by the directed checks.
  int               ncyc = 0;
  int               glog[$];
  int               gcyc[$];
  int               rv0_n = 0, rv1_n = 0, rv0_cyc = 0;
  logic [WIDTH-1:0] rv0_data = '0;
  logic [7:0]       cap_adr = '0;
  logic [WIDTH-1:0] cap_wdata = '0;
  logic             cap_we = 1'b0;

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (!reset) begin
      chk("p0_gnt", p0_gnt, m_gnt0);
      chk("p1_gnt", p1_gnt, m_gnt1);
      chk("p0_rvalid", p0_rvalid, m_rv0);
      chk("p1_rvalid", p1_rvalid, m_rv1);
      chk("sram_cs", sram_cs, m_cs);
      chk("sram_we", sram_we, m_we);
      if (m_cs) begin
        chk("sram_adr", sram_adr, m_adr);
        chk("sram_wdata", sram_wdata, m_wdata);
      end
      if (m_rv0) chk("p0_rdata", p0_rdata, m_rdata);
      if (m_rv1) chk("p1_rdata", p1_rdata, m_rdata);
      if (p0_gnt) begin glog.push_back(0); gcyc.push_back(ncyc); end
      if (p1_gnt) begin glog.push_back(1); gcyc.push_back(ncyc); end
      if (sram_cs) begin cap_adr = sram_adr; cap_wdata = sram_wdata; cap_we = sram_we; end
      if (p0_rvalid) begin rv0_n++; rv0_data = p0_rdata; rv0_cyc = ncyc; end
      if (p1_rvalid) rv1_n++;
    end
  end

  // Raise the selected requests, drop each on its grant, then let the bus drain.
  task automatic drive2(input bit a0, input bit w0, input logic [31:0] ad0, input logic [31:0] wd0,
                        input bit a1, input bit w1, input logic [31:0] ad1, input logic [31:0] wd1);
    bit pend0, pend1;
    int n;
    @(negedge clk);
    if (a0) begin p0_req = 1; p0_we = w0; p0_adr = ad0; p0_wdata = wd0; end
    if (a1) begin p1_req = 1; p1_we = w1; p1_adr = ad1; p1_wdata = wd1; end
    pend0 = a0; pend1 = a1; n = 0;
    while ((pend0 || pend1) && n < 50) begin
      @(negedge clk);
      n++;
      if (pend0 && p0_gnt) begin pend0 = 0; p0_req = 0; end
      if (pend1 && p1_gnt) begin pend1 = 0; p1_req = 0; end
    end
    chk("drive_timeout", {30'd0, pend1, pend0}, 32'd0);
    p0_req = 0; p1_req = 0;
    repeat (4) @(negedge clk);
  endtask

  int s_g, s_r0, s_r1, n, zeros;

  initial begin
    p0_req = 0; p0_we = 0; p0_adr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_adr = '0; p1_wdata = '0;
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_sram_cs", sram_cs, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_adr", sram_adr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    reset = 0;
    @(negedge clk);

    // Simultaneous reads straight after reset.
    s_g = glog.size(); s_r0 = rv0_n; s_r1 = rv1_n;
    drive2(1, 0, 32'd0, 32'd0, 1, 0, 32'd4, 32'd0);
    chk("tie_ngnt", glog.size() - s_g, 2);
`ifdef MEM_ARB_RR_EN
    chk("tie_first", glog[s_g], 0);
    chk("tie_second", glog[s_g+1], 1);
`else
    chk("tie_first", glog[s_g], 1);
    chk("tie_second", glog[s_g+1], 0);
`endif
    chk("tie_gap", gcyc[s_g+1] - gcyc[s_g], 3);
    chk("tie_rv0", rv0_n - s_r0, 1);
    chk("tie_rv1", rv1_n - s_r1, 1);

    // Simultaneous writes: write occupancy spaces the grants by two cycles.
    s_g = glog.size();
    drive2(1, 1, 32'd40, 32'h11, 1, 1, 32'd44, 32'h22);
    chk("wtie_gap", gcyc[s_g+1] - gcyc[s_g], 2);

    // Both ports hold read requests for eight transactions.
    s_g = glog.size();
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_adr = 32'h10;
    p1_req = 1; p1_we = 0; p1_adr = 32'h14;
    n = 0;
    while (glog.size() - s_g < 8 && n < 60) begin
      @(negedge clk);
      n++;
    end
    p0_req = 0; p1_req = 0;
    repeat (5) @(negedge clk);
    chk("hold_ngnt", glog.size() - s_g, 8);
    zeros = 0;
    for (int i = 0; i < 8; i++) if (glog[s_g+i] == 0) zeros++;
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 8; i++) chk($sformatf("hold_alt%0d", i), glog[s_g+i], i % 2);
`else
    chk("hold_p0_grants", zeros, 0);
`endif

    // Core write alone, then read back.
    s_g = glog.size(); s_r0 = rv0_n; s_r1 = rv1_n;
    drive2(1, 1, 32'd20, 32'd7, 0, 0, 32'd0, 32'd0);
    chk("w_adr", cap_adr, 5);
    chk("w_wdata", cap_wdata, 7);
    chk("w_we", cap_we, 1);
    chk("w_ngnt", glog.size() - s_g, 1);
    chk("w_port", glog[s_g], 0);
    chk("w_norv", (rv0_n - s_r0) + (rv1_n - s_r1), 0);

    s_g = glog.size(); s_r0 = rv0_n; s_r1 = rv1_n;
    drive2(1, 0, 32'd20, 32'd0, 0, 0, 32'd0, 32'd0);
    chk("r_rdata", rv0_data, 7);
    chk("r_rv0", rv0_n - s_r0, 1);
    chk("r_rv1", rv1_n - s_r1, 0);
    chk("r_lat", rv0_cyc - gcyc[s_g], 2);

    // Address wrap through the host port.
    drive2(0, 0, 32'd0, 32'd0, 1, 1, 32'h408, 32'hDEADBEEF);
    chk("wrap_wadr", cap_adr, 2);
    drive2(1, 0, 32'd8, 32'd0, 0, 0, 32'd0, 32'd0);
    chk("wrap_radr", cap_adr, 2);
    chk("wrap_rdata", rv0_data, 32'hDEADBEEF);

    // Reset during the ACCESS cycle of a host read.
    s_r1 = rv1_n;
    @(negedge clk);
    p1_req = 1; p1_we = 0; p1_adr = 32'd12;
    n = 0;
    while (!p1_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_gnt_seen", p1_gnt, 1);
    p1_req = 0;
    #2 reset = 1;
    #1;
    chk("abort_cs", sram_cs, 0);
    chk("abort_gnt", p1_gnt, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    chk("abort_norv", rv1_n - s_r1, 0);
    s_g = glog.size();
    drive2(1, 0, 32'd0, 32'd0, 1, 0, 32'd4, 32'd0);
`ifdef MEM_ARB_RR_EN
    chk("post_rst_tie", glog[s_g], 0);
`else
    chk("post_rst_tie", glog[s_g], 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
